// File: rtl/m_irqcapture.sv
// ---------------------------------------------------------------------------
// m_irqcapture
//   Captures mtime-tick and minstret-overflow events from the ALU stage,
//   keeps them pending until the core acknowledges them, and arbitrates a
//   single registered interrupt request (overflow has priority over tick).
//
// Configuration macro:
//   MIDGETV_MINSTRET_IRQ_EN  defined   -> overflow interrupt path present
//                            undefined -> alu_minstretofl / ofl_ie ignored,
//                                         ofl_pend and irq_cause tied to 0
//
// Parameters:
//   TICKCNTW   width of the pending-tick counter (2..6)
//
// Ports:
//   CLK_I            clock, all state on rising edge
//   RST_N_I          synchronous active-low reset
//   alu_tapout       one-cycle mtime-increment event
//   alu_minstretofl  one-cycle minstret-overflow event
//   tick_ie          timer interrupt enable
//   ofl_ie           overflow interrupt enable
//   irq_ack          acknowledge strobe from the core
//   ack_sel          acknowledged source (0 = tick, 1 = overflow)
//   lost_clr         clears tick_lost
//   irq_req          registered interrupt request level
//   irq_cause        0 = tick, 1 = overflow (valid while irq_req = 1)
//   tick_pend        number of pending ticks
//   ofl_pend         overflow event pending
//   tick_lost        sticky: a tick was dropped at counter saturation
// ---------------------------------------------------------------------------
module m_irqcapture #(
  parameter int TICKCNTW = 3
) (
  input  logic                CLK_I,
  input  logic                RST_N_I,
  input  logic                alu_tapout,
  input  logic                alu_minstretofl,
  input  logic                tick_ie,
  input  logic                ofl_ie,
  input  logic                irq_ack,
  input  logic                ack_sel,
  input  logic                lost_clr,
  output logic                irq_req,
  output logic                irq_cause,
  output logic [TICKCNTW-1:0] tick_pend,
  output logic                ofl_pend,
  output logic                tick_lost
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_TICK = 2'd1,
    ST_REQ_OFL  = 2'd2
  } state_e;

  localparam logic [TICKCNTW-1:0] TICK_MAX  = {TICKCNTW{1'b1}};
  localparam logic [TICKCNTW-1:0] TICK_ONE  = {{(TICKCNTW-1){1'b0}}, 1'b1};
  localparam logic [TICKCNTW-1:0] TICK_ZERO = {TICKCNTW{1'b0}};

  state_e                state_q,     state_d;
  logic [TICKCNTW-1:0]   tick_pend_q, tick_pend_d;
  logic                  ofl_pend_q,  ofl_pend_d;
  logic                  tick_lost_q, tick_lost_d;
  logic                  irq_req_q,   irq_req_d;
  logic                  irq_cause_q, irq_cause_d;

  logic                  tick_dec_s;
  logic                  lost_set_s;
  logic                  ofl_dec_s;
  logic                  ofl_req_s;
  logic                  ofl_en_s;

  // A tick is consumed only by a matching ack while the tick request is up.
  assign tick_dec_s = (state_q == ST_REQ_TICK) & irq_ack & ~ack_sel;

`ifdef MIDGETV_MINSTRET_IRQ_EN
  assign ofl_dec_s = (state_q == ST_REQ_OFL) & irq_ack & ack_sel;
  assign ofl_en_s  = ofl_ie;
  assign ofl_req_s = ofl_pend_q & ofl_ie;
`else
  logic unused_ok;
  assign unused_ok = alu_minstretofl ^ ofl_ie;
  assign ofl_dec_s = 1'b0;
  assign ofl_en_s  = 1'b0;
  assign ofl_req_s = 1'b0;
`endif

  // Pending tick counter with saturation; a tap paired with a consuming
  // ack cancels out, so it can never be counted as lost.
  always_comb begin
    tick_pend_d = tick_pend_q;
    lost_set_s  = 1'b0;
    if (alu_tapout && !tick_dec_s) begin
      if (tick_pend_q == TICK_MAX) begin
        lost_set_s = 1'b1;
      end else begin
        tick_pend_d = tick_pend_q + TICK_ONE;
      end
    end else if (!alu_tapout && tick_dec_s) begin
      tick_pend_d = tick_pend_q - TICK_ONE;
    end else begin
      tick_pend_d = tick_pend_q;
    end
  end

  // Sticky lost flag: a new drop wins over a simultaneous clear.
  always_comb begin
    tick_lost_d = lost_set_s | (tick_lost_q & ~lost_clr);
  end

  // Overflow pending flag: a new event wins over a simultaneous consume.
  always_comb begin
`ifdef MIDGETV_MINSTRET_IRQ_EN
    ofl_pend_d = alu_minstretofl | (ofl_pend_q & ~ofl_dec_s);
`else
    ofl_pend_d = 1'b0;
`endif
  end

  // Arbitration next-state; every request returns through IDLE, which
  // guarantees at least one low cycle of irq_req between requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ofl_req_s) begin
          state_d = ST_REQ_OFL;
        end else if ((tick_pend_q != TICK_ZERO) && tick_ie) begin
          state_d = ST_REQ_TICK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ_TICK: begin
        if (tick_dec_s || !tick_ie) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ_TICK;
        end
      end
      ST_REQ_OFL: begin
        if (ofl_dec_s || !ofl_en_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ_OFL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flops mirror the next state so irq_req/irq_cause track state_q.
  always_comb begin
    irq_req_d = (state_d != ST_IDLE);
`ifdef MIDGETV_MINSTRET_IRQ_EN
    irq_cause_d = (state_d == ST_REQ_OFL);
`else
    irq_cause_d = 1'b0;
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q     <= ST_IDLE;
      tick_pend_q <= TICK_ZERO;
      ofl_pend_q  <= 1'b0;
      tick_lost_q <= 1'b0;
      irq_req_q   <= 1'b0;
      irq_cause_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_pend_q <= tick_pend_d;
      ofl_pend_q  <= ofl_pend_d;
      tick_lost_q <= tick_lost_d;
      irq_req_q   <= irq_req_d;
      irq_cause_q <= irq_cause_d;
    end
  end

  assign irq_req   = irq_req_q;
  assign irq_cause = irq_cause_q;
  assign tick_pend = tick_pend_q;
  assign ofl_pend  = ofl_pend_q;
  assign tick_lost = tick_lost_q;

endmodule

// File: tb/tb_m_irqcapture.sv
// ---------------------------------------------------------------------------
// tb_m_irqcapture
//   Directed stimulus for m_irqcapture (TICKCNTW = 3). Before each clock
//   edge the stimulus pushes the hand-computed outputs expected after that
//   edge into a queue; a separate monitor pops and compares on the falling
//   edge.
// ---------------------------------------------------------------------------
module tb_m_irqcapture;

  localparam int TW = 3;

  logic          clk;
  logic          rst_n;
  logic          alu_tapout;
  logic          alu_minstretofl;
  logic          tick_ie;
  logic          ofl_ie;
  logic          irq_ack;
  logic          ack_sel;
  logic          lost_clr;
  logic          irq_req;
  logic          irq_cause;
  logic [TW-1:0] tick_pend;
  logic          ofl_pend;
  logic          tick_lost;

  typedef struct {
    int            cyc;
    string         name;
    logic          req;
    logic          cause;
    logic [TW-1:0] tp;
    logic          op;
    logic          lost;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt   = 0;
  int   n_cmp     = 0;
  int   n_mis     = 0;
  bit   stim_done = 1'b0;

  m_irqcapture #(.TICKCNTW(TW)) dut (
    .CLK_I           (clk),
    .RST_N_I         (rst_n),
    .alu_tapout      (alu_tapout),
    .alu_minstretofl (alu_minstretofl),
    .tick_ie         (tick_ie),
    .ofl_ie          (ofl_ie),
    .irq_ack         (irq_ack),
    .ack_sel         (ack_sel),
    .lost_clr        (lost_clr),
    .irq_req         (irq_req),
    .irq_cause       (irq_cause),
    .tick_pend       (tick_pend),
    .ofl_pend        (ofl_pend),
    .tick_lost       (tick_lost)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to align expectations with DUT outputs.
  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  // Monitor: compare every expectation due on this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (e.cyc < cyc_cnt) begin
          n_mis++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc_cnt);
        end else if ({irq_req, irq_cause, tick_pend, ofl_pend, tick_lost} !==
                     {e.req, e.cause, e.tp, e.op, e.lost}) begin
          n_mis++;
          $display("FAIL %s: got req=%b cause=%b tick_pend=%0d ofl_pend=%b lost=%b, want req=%b cause=%b tick_pend=%0d ofl_pend=%b lost=%b",
                   e.name, irq_req, irq_cause, tick_pend, ofl_pend, tick_lost,
                   e.req, e.cause, e.tp, e.op, e.lost);
        end
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Push the outputs expected right after the next rising edge.
  task automatic expect_next(input string nm, input logic req, input logic cause,
                             input logic [TW-1:0] tp, input logic op, input logic lost);
    exp_t e;
    e.cyc = cyc_cnt + 1;
    e.name = nm;
    e.req = req;
    e.cause = cause;
    e.tp = tp;
    e.op = op;
    e.lost = lost;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and advance past the rising edge.
  task automatic step(input logic tap, input logic ofl, input logic tie, input logic oie,
                      input logic ack, input logic sel, input logic clr);
    alu_tapout      = tap;
    alu_minstretofl = ofl;
    tick_ie         = tie;
    ofl_ie          = oie;
    irq_ack         = ack;
    ack_sel         = sel;
    lost_clr        = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state.
    expect_next("rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Single tick: pend at +1, request at +2, ack consumes.
    expect_next("a_tap", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("a_req", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("a_ack", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_next("a_idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation with tick_ie=0: 9 taps -> 7 pending, lost set.
    for (int i = 1; i <= 9; i++) begin
      expect_next("b_tap", 1'b0, 1'b0, (i > 7) ? 3'd7 : 3'(i), 1'b0, (i > 7) ? 1'b1 : 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    expect_next("b_clr", 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Saturated request: wrong-sel ack ignored, tap+ack cancels, no loss.
    expect_next("c_req", 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("c_badsel", 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_next("c_tapack", 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_next("c_rereq", 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while requesting.
    rst_n = 1'b0;
    expect_next("d_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Enable dropped mid-request: back to idle, pending retained; ack in idle ignored.
    expect_next("d_tap", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("d_req", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("d_drop", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("d_idleack", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Build tick_pend=5 with request up, then one reset cycle.
    for (int j = 2; j <= 5; j++) begin
      expect_next("e_tap", 1'b1, 1'b0, 3'(j), 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    expect_next("e_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_next("e_post", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef MIDGETV_MINSTRET_IRQ_EN
    // Overflow priority over two pending ticks.
    expect_next("f_tap1", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("f_tap2ofl", 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next("f_oflreq", 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("f_badsel", 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_next("f_oflack", 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_next("f_tickreq1", 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("f_tickack1", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_next("f_tickreq2", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("f_tickack2", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_next("f_idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overflow event coinciding with its ack stays pending.
    expect_next("g_ofl", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("g_req", 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("g_oflack", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_next("g_rereq", 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("g_ack", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
`else
    // Overflow path compiled out: events and acks have no effect.
    expect_next("h_ofl", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_next("h_oflack", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_next("h_idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
